// File: rtl/uart_bps_gen.sv
// UART bit-period generator: mid-bit and end-of-bit strobes over a frame.
// Optional 16x oversample tick enabled by defining UART_BPS_OS_EN.
module uart_bps_gen #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 5207,
  parameter int FRAME_BITS  = 10,
  parameter int MIN_DIV     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_start,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  output logic             bps_sig,
  output logic             bit_end,
  output logic [3:0]       bit_idx,
  output logic             frame_done,
  output logic             busy,
  output logic             load_err
`ifdef UART_BPS_OS_EN
  ,
  output logic             os_tick
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [3:0]       LAST = 4'(FRAME_BITS - 1);
  localparam logic [DIV_W-1:0] DEF  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN  = DIV_W'(MIN_DIV);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       idx_q, idx_d;
  logic             err_q, err_d;

  logic             run;
  logic             at_end;
  logic [DIV_W-1:0] half;

  assign run    = (state_q == RUN);
  assign at_end = (cnt_q == div_q);
  // (div+1)>>1 without widening
  assign half   = (div_q >> 1) + DIV_W'(div_q[0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    div_d   = div_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (cnt_start) state_d = RUN;
      end
      RUN: begin
        if (!cnt_start) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (at_end) begin
          cnt_d = '0;
          if (idx_q == LAST) state_d = DONE;
          else idx_d = idx_q + 4'd1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      DONE: begin
        cnt_d = '0;
        idx_d = LAST;
        if (!cnt_start) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    if (div_load) begin
      if (state_q == IDLE && div_val >= MIN) div_d = div_val;
      else err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DEF;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign bps_sig    = run && (cnt_q == half);
  assign bit_end    = run && at_end;
  // an abort on the last bit_end wins over completion
  assign frame_done = bit_end && (idx_q == LAST) && cnt_start;
  assign busy       = (state_q != IDLE);
  assign bit_idx    = idx_q;
  assign load_err   = err_q;

`ifdef UART_BPS_OS_EN
  logic [DIV_W-1:0] os_q, os_d;
  logic [DIV_W-1:0] os_top;

  assign os_top = div_q >> 4;

  always_comb begin
    os_d = '0;
    if (run && cnt_start && !at_end) begin
      if (os_q == os_top) os_d = '0;
      else os_d = os_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) os_q <= '0;
    else        os_q <= os_d;
  end

  assign os_tick = run && (os_q == os_top);
`endif

endmodule

// File: tb/tb_uart_bps_gen.sv
// Bench for uart_bps_gen: strobe events scoreboarded by cycle stamp.
// Optional os_tick checks run when UART_BPS_OS_EN is defined.
module tb_uart_bps_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_start = 1'b0;
  logic        div_load = 1'b0;
  logic [15:0] div_val = '0;
  logic        bps_sig, bit_end, frame_done, busy, load_err;
  logic [3:0]  bit_idx;
`ifdef UART_BPS_OS_EN
  logic        os_tick;
`endif

  uart_bps_gen dut (
    .clk(clk),
    .rst_n(rst_n),
    .cnt_start(cnt_start),
    .div_load(div_load),
    .div_val(div_val),
    .bps_sig(bps_sig),
    .bit_end(bit_end),
    .bit_idx(bit_idx),
    .frame_done(frame_done),
    .busy(busy),
    .load_err(load_err)
`ifdef UART_BPS_OS_EN
    ,
    .os_tick(os_tick)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    bit       bps;
    bit       be;
    bit       fd;
    bit       le;
    bit [3:0] idx;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input bit b, input bit e,
                         input bit f, input bit l, input bit [3:0] i);
    ev_t ev;
    ev = '{c, b, e, f, l, i};
    for (int k = 0; k < q.size(); k++) begin
      if (q[k].cyc == c) begin
        q[k].bps |= b;
        q[k].be  |= e;
        q[k].fd  |= f;
        q[k].le  |= l;
        if (b || e) q[k].idx = i;
        return;
      end
      if (q[k].cyc > c) begin
        q.insert(k, ev);
        return;
      end
    end
    q.push_back(ev);
  endtask

  // c0: cycle on which cnt first reads 0 in RUN
  task automatic push_frame(input int c0, input int dv,
                            input int nb, input bit full);
    int p, h;
    p = dv + 1;
    h = (dv + 1) >> 1;
    for (int b = 0; b < nb; b++) begin
      push_ev(c0 + b * p + h, 1, 0, 0, 0, 4'(b));
      push_ev(c0 + b * p + dv, 0, 1, full && (b == nb - 1), 0, 4'(b));
    end
  endtask

  always @(negedge clk) begin
    if (bps_sig || bit_end || frame_done || load_err) begin
      ev_t e;
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: cyc %0d bps %b be %b fd %b le %b",
                 cyc, bps_sig, bit_end, frame_done, load_err);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.bps != bps_sig || e.be != bit_end ||
            e.fd != frame_done || e.le != load_err ||
            ((e.bps || e.be) && e.idx != bit_idx)) begin
          n_err++;
          $display("FAIL strobe_event: got cyc %0d b%b e%b f%b l%b i%0d want cyc %0d b%b e%b f%b l%b i%0d",
                   cyc, bps_sig, bit_end, frame_done, load_err, bit_idx,
                   e.cyc, e.bps, e.be, e.fd, e.le, e.idx);
        end
      end
    end
  end

  initial begin
    int n;
    // reset state
    tick(); tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_idx", int'(bit_idx), 0);
    chk("rst_strobes", int'({bps_sig, bit_end, frame_done, load_err}), 0);
    rst_n = 1'b1;
    tick();

    // rejected divisor below minimum
    div_load = 1'b1; div_val = 16'd2;
    push_ev(cyc + 1, 0, 0, 0, 1, 0);
    tick();
    div_load = 1'b0;
    tick(); tick();

    // full default frame: period 5208, bps at 2604
    n = cyc;
    cnt_start = 1'b1;
    push_frame(n + 1, 5207, 10, 1);
    wait_to(n + 52080 + 3);
    chk("done_busy", int'(busy), 1);
    chk("done_idx", int'(bit_idx), 9);
    cnt_start = 1'b0;
    tick();
    chk("idle_busy", int'(busy), 0);
    chk("idle_idx", int'(bit_idx), 0);

    // load 9 together with start; load during RUN rejected
    n = cyc;
    div_load = 1'b1; div_val = 16'd9; cnt_start = 1'b1;
    push_frame(n + 1, 9, 10, 1);
    tick();
    div_load = 1'b0;
    wait_to(n + 3);
    div_load = 1'b1; div_val = 16'd50;
    push_ev(n + 4, 0, 0, 0, 1, 0);
    tick();
    div_load = 1'b0;
    chk("run_busy", int'(busy), 1);
    wait_to(n + 102);
    chk("done9_idx", int'(bit_idx), 9);
    cnt_start = 1'b0;
    tick(); tick();

    // abort at bit 3, then restart from bit 0
    n = cyc;
    cnt_start = 1'b1;
    push_frame(n + 1, 9, 3, 0);
    wait_to(n + 33);
    chk("abort_pre_idx", int'(bit_idx), 3);
    cnt_start = 1'b0;
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_idx", int'(bit_idx), 0);
    tick();
    n = cyc;
    cnt_start = 1'b1;
    push_frame(n + 1, 9, 1, 0);
    wait_to(n + 1);
    chk("restart_idx0", int'(bit_idx), 0);
    wait_to(n + 11);
    chk("restart_idx1", int'(bit_idx), 1);
    cnt_start = 1'b0;
    tick(); tick();

    // reset mid-frame after loading 99
    div_load = 1'b1; div_val = 16'd99;
    tick();
    div_load = 1'b0;
    n = cyc;
    cnt_start = 1'b1;
    push_frame(n + 1, 99, 1, 0);
    wait_to(n + 121);
    rst_n = 1'b0;
    cnt_start = 1'b0;
    #1;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_idx", int'(bit_idx), 0);
    chk("mrst_strobes", int'({bps_sig, bit_end, frame_done, load_err}), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // divisor back to default after reset
    n = cyc;
    cnt_start = 1'b1;
    push_frame(n + 1, 5207, 1, 0);
    wait_to(n + 5211);
    chk("post_rst_idx", int'(bit_idx), 1);
    cnt_start = 1'b0;
    tick(); tick();

`ifdef UART_BPS_OS_EN
    begin
      int ticks, first;
      div_load = 1'b1; div_val = 16'd159;
      tick();
      div_load = 1'b0;
      n = cyc;
      cnt_start = 1'b1;
      push_frame(n + 1, 159, 1, 0);
      ticks = 0;
      first = -1;
      tick();
      for (int k = 0; k < 160; k++) begin
        if (os_tick) begin
          if (first < 0) first = k;
          ticks++;
        end
        tick();
      end
      chk("os_first_cnt", first, 9);
      chk("os_ticks_per_bit", ticks, 16);
      cnt_start = 1'b0;
      tick();
      chk("os_idle", int'(os_tick), 0);
      tick();
    end
`endif

    tick(); tick();
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
